// File: rtl/sammm_pkg.sv
// Shared defaults, derived widths and controller state encoding
// for the SAMMM result read-out path.
package sammm_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SIZE_NUM   = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int RES_W          = 2 * DEF_DATA_WIDTH;
    localparam int IDX_W          = $clog2(DEF_SIZE_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sammm_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may
// occur in the same cycle, including when full.
module sammm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot, so a push at full is still safe.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sammm_result_reader.sv
// Drains SAMMM results through a credit-limited capture FIFO and
// streams them out row-major with coordinates and a last flag.
module sammm_result_reader
    import sammm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIZE_NUM   = DEF_SIZE_NUM,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int RW = 2 * DATA_WIDTH,
    localparam int IW = $clog2(SIZE_NUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          read,
    input  logic [RW-1:0] result_i,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [RW-1:0] m_data,
    output logic [IW-1:0] m_row,
    output logic [IW-1:0] m_col,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TOTAL = SIZE_NUM * SIZE_NUM;
    localparam int ISW   = $clog2(TOTAL) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_NUM - 1);

    rd_state_e      state_q, state_d;
    logic [ISW-1:0] issued_q, issued_d;
    logic [IW-1:0]  row_q, row_d, col_q, col_d;
    logic           read_q, done_q, done_d;

    logic [RW-1:0]  head;
    logic [CW-1:0]  fifo_cnt;
    logic           fifo_empty, fifo_full;
    logic           pop, credit, is_last;

    sammm_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (read_q),
        .data_i  (result_i),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Count the in-flight read so a capture always finds a free slot.
    assign credit  = (fifo_cnt + CW'(read_q)) < CW'(FIFO_DEPTH);
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? head : '0;
    assign m_row   = row_q;
    assign m_col   = col_q;
    assign is_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign m_last  = m_valid && is_last;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        read     = 1'b0;

        if (pop) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = row_q + IW'(1);
            end else begin
                col_d = col_q + IW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    issued_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            S_ISSUE: begin
                if (credit && (issued_q < ISW'(TOTAL))) begin
                    read     = 1'b1;
                    issued_d = issued_q + ISW'(1);
                    if (issued_q == ISW'(TOTAL - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (pop && is_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            row_q    <= row_d;
            col_q    <= col_d;
            read_q   <= read;
            done_q   <= done_d;
        end
    end

endmodule
